uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of top_uart.
- Consumes the UART's rx_data/rdy pair, acknowledges each byte with a one-cycle rdy_clr pulse, and stores bytes in a DEPTH-entry FIFO.
- The host drains the FIFO through a first-word-fall-through read port.
- Decouples host read latency from UART byte timing and flags overruns.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo_sync_fifo.sv | 77 +++++++
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 tb/tb_uart_rx_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receive-side buffer.
//   DATA_W     - byte width carried from top_uart to the host
//   FIFO_DEPTH - default number of FIFO entries (power of 2)
//   FIFO_AW    - pointer width matching FIFO_DEPTH
//   cap_state_e - capture FSM encoding
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: DEPTH x DATA_W first-word-fall-through FIFO.
//   clk, rst_n  - clock, asynchronous active-low reset (storage not reset)
//   wr_en       - push wr_data; honoured when not full or when popping too
//   wr_data     - byte to push
//   rd_en       - pop the head; ignored when empty
//   rd_data     - head entry, combinational from storage
//   empty, full - registered occupancy flags derived from count
//   count       - registered occupancy 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_next_s;
  logic              empty_r;
  logic              full_r;
  logic              rd_fire_s;
  logic              wr_fire_s;

  // A push into a full FIFO is only legal because the same-cycle pop frees a slot.
  assign rd_fire_s = rd_en & ~empty_r;
  assign wr_fire_s = wr_en & (~full_r | rd_fire_s);

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({wr_fire_s, rd_fire_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and flags; pointers wrap naturally since DEPTH == 2**AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (wr_fire_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_fire_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
      empty_r <= (count_next_s == '0);
      full_r  <= (count_next_s == (AW+1)'(DEPTH));
    end
  end

  // Storage array, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign empty   = empty_r;
  assign full    = full_r;
  assign count   = count_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from top_uart into a FWFT FIFO for the host.
//   clk, rst_n      - clock, asynchronous active-low reset
//   rx_data, rdy    - byte and level ready flag from top_uart
//   rdy_clr         - one-cycle acknowledge pulse back to top_uart
//   rd_en, rd_data  - host pop request and head-of-FIFO byte
//   empty, full     - FIFO occupancy flags
//   count           - occupancy 0..DEPTH
//   overrun         - sticky flag: a byte was dropped on a full FIFO
//   ovr_clr         - clears overrun (a same-cycle drop wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rdy,
  output logic              rdy_clr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overrun,
  input  logic              ovr_clr
);

  cap_state_e state_r;
  logic       rdy_clr_r;
  logic       overrun_r;
  logic       capture_s;
  logic       accept_s;
  logic       drop_s;

  // A byte is taken only on the IDLE->ACK edge; a full FIFO accepts it only
  // when the host pops in the same cycle.
  assign capture_s = (state_r == IDLE) & rdy;
  assign accept_s  = capture_s & (~full | (rd_en & ~empty));
  assign drop_s    = capture_s & ~accept_s;

  // Capture FSM with registered acknowledge; WAIT_LOW blocks a second capture
  // of the same byte while top_uart is still clearing rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rdy_clr_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rdy) begin
            state_r   <= ACK;
            rdy_clr_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            rdy_clr_r <= 1'b0;
          end
        end
        ACK: begin
          state_r   <= WAIT_LOW;
          rdy_clr_r <= 1'b0;
        end
        WAIT_LOW: begin
          rdy_clr_r <= 1'b0;
          if (!rdy) state_r <= IDLE;
          else      state_r <= WAIT_LOW;
        end
        default: begin
          state_r   <= IDLE;
          rdy_clr_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a drop in the same cycle as ovr_clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun_r <= 1'b0;
    else if (drop_s)  overrun_r <= 1'b1;
    else if (ovr_clr) overrun_r <= 1'b0;
    else              overrun_r <= overrun_r;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept_s),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign rdy_clr = rdy_clr_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (DEPTH=16).
// A queue-based reference model predicts acknowledge, occupancy, head byte
// and overrun every cycle; directed vectors and sequences cover the corners.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rdy;
  logic       rdy_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;

  int n_cmp;
  int n_fail;

  uart_rx_fifo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rdy     (rdy),
    .rdy_clr (rdy_clr),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
    .ovr_clr (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_can;   // receiver will take a byte as soon as rdy is high
  bit         m_hold;  // the cycle right after a capture ignores rdy
  bit         m_clr;   // a byte was taken on the last edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_can  = 1'b1;
    m_hold = 1'b0;
    m_clr  = 1'b0;
  endtask

  // Advance one clock edge, update the model from the inputs that were
  // presented, and compare every observable output.
  task automatic step();
    bit cap, pop, push;
    @(posedge clk);
    cap = rdy && m_can;
    if (cap) begin
      m_can = 1'b0; m_hold = 1'b1;
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else if (!m_can && !rdy) begin
      m_can = 1'b1;
    end
    m_clr = cap;
    pop  = rd_en && (mq.size() > 0);
    push = cap && ((mq.size() < 16) || pop);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(rx_data);
    if (cap && !push) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    #1;
    chk("rdy_clr", 32'(rdy_clr), 32'(m_clr));
    chk("count",   32'(count),   32'(mq.size()));
    chk("empty",   32'(empty),   32'(mq.size() == 0));
    chk("full",    32'(full),    32'(mq.size() == 16));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
  endtask

  // Present a byte the way top_uart does, wait for the acknowledge, drop rdy
  // and let the receiver return to idle. rd/oc apply on the capture edge.
  task automatic send_byte(input logic [7:0] d, input bit rd, input bit oc);
    bit got;
    got = 1'b0;
    rdy = 1'b1; rx_data = d; rd_en = rd; ovr_clr = oc;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      if (m_clr) got = 1'b1;
    end
    rdy = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    if (!got) chk("ack_timeout", 32'(got), 32'd1);
    for (int k = 0; k < 8 && !m_can; k++) step();
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    chk(name, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       rd;
    logic       oc;
    logic [4:0] e_count;
    logic       e_clr;
    logic       e_ovr;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[13];
  bit   acked;

  initial begin
    n_cmp = 0; n_fail = 0;
    rdy = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy_clr", 32'(rdy_clr), 32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle-by-cycle vectors: single byte, pop, FWFT update, held rdy.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'hA5};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'h3C};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h3C};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h3C};
    vecs[7]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 8'h5A};
    vecs[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h5A};
    vecs[9]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h5A};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h5A};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 13; i++) begin
      rdy = vecs[i].rdy; rx_data = vecs[i].data;
      rd_en = vecs[i].rd; ovr_clr = vecs[i].oc;
      step();
      chk("vec_count",   32'(count),   32'(vecs[i].e_count));
      chk("vec_rdy_clr", 32'(rdy_clr), 32'(vecs[i].e_clr));
      chk("vec_overrun", 32'(overrun), 32'(vecs[i].e_ovr));
      if (vecs[i].e_count != 5'd0) chk("vec_rd_data", 32'(rd_data), 32'(vecs[i].e_rd));
    end
    rdy = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    step();

    // Burst with wrap: 12 writes, 8 pops, 8 more writes, drain.
    do_reset();
    for (int i = 0; i < 12; i++) send_byte(8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pop_check("wrap_order", 8'(i));
    for (int i = 12; i < 20; i++) send_byte(8'(i), 1'b0, 1'b0);
    chk("wrap_count", 32'(count), 32'd12);
    for (int i = 8; i < 20; i++) pop_check("wrap_order", 8'(i));
    chk("wrap_empty",   32'(empty),   32'd1);
    chk("wrap_overrun", 32'(overrun), 32'd0);

    // Overrun: fill, then one more byte is acknowledged but dropped.
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    chk("ovr_full", 32'(full), 32'd1);
    send_byte(8'hEE, 1'b0, 1'b0);
    chk("ovr_set",   32'(overrun), 32'd1);
    chk("ovr_count", 32'(count),   32'd16);
    for (int i = 0; i < 16; i++) pop_check("ovr_order", 8'h10 + 8'(i));
    chk("ovr_drained", 32'(empty), 32'd1);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Full plus simultaneous pop: the new byte is kept, no overrun.
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b0, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0);
    chk("fullrd_count",   32'(count),   32'd16);
    chk("fullrd_overrun", 32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) pop_check("fullrd_order", 8'h20 + 8'(i));
    pop_check("fullrd_last", 8'h77);

    // Sticky overrun: a drop coinciding with ovr_clr keeps the flag.
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0, 1'b0);
    send_byte(8'hE1, 1'b0, 1'b0);
    chk("sticky_set", 32'(overrun), 32'd1);
    send_byte(8'hE2, 1'b0, 1'b1);
    chk("sticky_drop_wins", 32'(overrun), 32'd1);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("sticky_clear", 32'(overrun), 32'd0);
    chk("sticky_head",  32'(rd_data), 32'h40);

    // Reset while in ACK with 5 entries, then a held rdy is captured once.
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i), 1'b0, 1'b0);
    rdy = 1'b1; rx_data = 8'h99;
    step();
    chk("midrst_pre_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    model_reset();
    rx_data = 8'h3C;
    #1;
    chk("midrst_rdy_clr", 32'(rdy_clr), 32'd0);
    chk("midrst_count",   32'(count),   32'd0);
    chk("midrst_empty",   32'(empty),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("midrst_cap_count", 32'(count),   32'd1);
    chk("midrst_cap_data",  32'(rd_data), 32'h3C);
    repeat (3) step();
    rdy = 1'b0;
    repeat (2) step();
    chk("midrst_single", 32'(count), 32'd1);

    // Randomized traffic against the model; read pressure changes midway
    // so both full and empty corners are visited.
    do_reset();
    acked = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rd_en   = ($urandom_range(99) < ((i < 1500) ? 12 : 60));
      ovr_clr = ($urandom_range(19) == 0);
      if (!rdy) begin
        if ($urandom_range(2) == 0) begin
          rdy = 1'b1; rx_data = 8'($urandom);
        end
      end else if (acked) begin
        if ($urandom_range(1) == 0) begin
          rdy = 1'b0; acked = 1'b0;
        end
      end
      step();
      if (m_clr) acked = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
